minx_bus_matrix: RTL and testbench

// - N-master bus arbiter and register-window router for the MINX SoC top level.
// - Master 0 (CPU) owns the bus by default. Masters 1..N-1 (PRC, future DMA) request it and are granted only at a CPU sync boundary.
// - Muxes the owner's address/data/strobes onto the shared bus.
// - Returns read data to all masters: the OR of the peripherals for accesses inside the register window, external data otherwise.

---
 rtl/minx_bus_matrix.sv | 200 ++++++++++++++++++++
 tb/tb_minx_bus_matrix.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/minx_bus_matrix.sv
// N-master bus arbiter and register-window read-data router for the MINX top level.
// Optional build macro BUS_MATRIX_ROUND_ROBIN_EN selects round-robin arbitration over masters 1..N-1.
module minx_bus_matrix #(
  parameter int unsigned NUM_MASTERS   = 2,
  parameter int unsigned NUM_SLAVES    = 13,
  parameter int unsigned ADDR_W        = 24,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned REG_BASE      = 32'h2000,
  parameter int unsigned REG_SIZE      = 32'h100,
  parameter logic [1:0]  MEM_READ_CODE = 2'b01,
  parameter int unsigned MAX_HOLD      = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clk_ce,
  input  logic                          cpu_sync,
  input  logic [NUM_MASTERS-1:0]        m_req,
  output logic [NUM_MASTERS-1:0]        m_ack,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS*2-1:0]      m_status,
  output logic [ADDR_W-1:0]             bus_addr,
  output logic [DATA_W-1:0]             bus_wdata,
  output logic                          bus_write,
  output logic                          bus_read,
  output logic [1:0]                    bus_status,
  output logic                          bus_write_dly,
  input  logic [NUM_SLAVES*DATA_W-1:0]  s_rdata,
  input  logic [DATA_W-1:0]             ext_rdata,
  output logic [DATA_W-1:0]             rdata,
  output logic                          in_window,
  output logic                          hold_timeout
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
  localparam int unsigned CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  // One extra bit so a window ending at the top of the address space cannot wrap.
  localparam logic [ADDR_W:0] WIN_LO = (ADDR_W+1)'(REG_BASE);
  localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(REG_SIZE);

  typedef enum logic [1:0] {OWN0, WAIT_SYNC, GRANT, TURN} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [CNT_W-1:0]       hold_q, hold_d;
  logic [NUM_MASTERS-1:0] barred_q, barred_d;
  logic                   wdly_q;
  logic                   tmo_q, tmo_d;
  logic [NUM_MASTERS-1:0] elig;
  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic                   grant_go;
  logic                   at_limit;
  logic [IDX_W-1:0]       sel;
  logic                   wr_sel, rd_sel;
  logic [DATA_W-1:0]      lanes_or;
`ifdef BUS_MATRIX_ROUND_ROBIN_EN
  logic [IDX_W-1:0]       rr_q, rr_d;
  int unsigned            start;
`endif

  always_comb begin
    elig      = m_req & ~barred_q;
    elig[0]   = 1'b0;
    win_found = 1'b0;
    win_idx   = '0;
`ifdef BUS_MATRIX_ROUND_ROBIN_EN
    // First pass covers rr_q..N-1, second pass wraps back to 1.
    start = 32'(rr_q);
    for (int unsigned k = 1; k < NUM_MASTERS; k++) begin
      if (!win_found && elig[k] && (k >= start)) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(k);
      end
    end
`endif
    for (int unsigned k = 1; k < NUM_MASTERS; k++) begin
      if (!win_found && elig[k]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    hold_d   = hold_q;
    barred_d = barred_q;
    tmo_d    = 1'b0;
    grant_go = 1'b0;
    at_limit = (MAX_HOLD != 0) && (32'(hold_q) == MAX_HOLD - 1);
`ifdef BUS_MATRIX_ROUND_ROBIN_EN
    rr_d     = rr_q;
`endif
    if (clk_ce) begin
      // A timed-out master becomes eligible again once its request is seen low.
      barred_d = barred_q & m_req;
      case (state_q)
        OWN0, WAIT_SYNC: begin
          if (!win_found)    state_d  = OWN0;
          else if (cpu_sync) grant_go = 1'b1;
          else               state_d  = WAIT_SYNC;
        end
        GRANT: begin
          hold_d = hold_q + 1'b1;
          if (!m_req[owner_q]) begin
            state_d = TURN;
          end else if (at_limit) begin
            state_d           = TURN;
            tmo_d             = 1'b1;
            barred_d[owner_q] = 1'b1;
          end
        end
        TURN:    state_d = OWN0;
        default: state_d = OWN0;
      endcase
      if (grant_go) begin
        state_d = GRANT;
        owner_d = win_idx;
        hold_d  = '0;
`ifdef BUS_MATRIX_ROUND_ROBIN_EN
        rr_d    = (32'(win_idx) + 1 >= NUM_MASTERS) ? IDX_W'(1) : win_idx + 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= OWN0;
      owner_q  <= '0;
      hold_q   <= '0;
      barred_q <= '0;
      wdly_q   <= 1'b0;
      tmo_q    <= 1'b0;
`ifdef BUS_MATRIX_ROUND_ROBIN_EN
      rr_q     <= IDX_W'(1);
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      hold_q   <= hold_d;
      barred_q <= barred_d;
      tmo_q    <= tmo_d;
`ifdef BUS_MATRIX_ROUND_ROBIN_EN
      rr_q     <= rr_d;
`endif
      if (clk_ce) wdly_q <= (state_q == TURN) ? 1'b0 : bus_write;
    end
  end

  always_comb begin
    m_ack = '0;
    case (state_q)
      OWN0, WAIT_SYNC: m_ack[0]       = 1'b1;
      GRANT:           m_ack[owner_q] = 1'b1;
      default:         m_ack          = '0;
    endcase
  end

  always_comb begin
    sel        = (state_q == GRANT) ? owner_q : '0;
    bus_addr   = m_addr[ADDR_W-1:0];
    bus_wdata  = m_wdata[DATA_W-1:0];
    bus_status = m_status[1:0];
    wr_sel     = m_write[0];
    rd_sel     = m_read[0];
    for (int unsigned k = 1; k < NUM_MASTERS; k++) begin
      if (k == 32'(sel)) begin
        bus_addr   = m_addr[k*ADDR_W +: ADDR_W];
        bus_wdata  = m_wdata[k*DATA_W +: DATA_W];
        bus_status = m_status[k*2 +: 2];
        wr_sel     = m_write[k];
        rd_sel     = m_read[k];
      end
    end
    // Strobes are forced low in reset and during the turnaround tick.
    bus_write = reset && (state_q != TURN) && wr_sel;
    bus_read  = reset && (state_q != TURN) && rd_sel;
  end

  always_comb begin
    in_window = ({1'b0, bus_addr} >= WIN_LO) && ({1'b0, bus_addr} < WIN_HI);
  end

  always_comb begin
    lanes_or = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      lanes_or = lanes_or | s_rdata[i*DATA_W +: DATA_W];
    end
    rdata = (in_window && (bus_status == MEM_READ_CODE)) ? lanes_or : ext_rdata;
  end

  assign bus_write_dly = wdly_q;
  assign hold_timeout  = tmo_q;

endmodule

// File: tb/tb_minx_bus_matrix.sv
// Scoreboard bench for minx_bus_matrix (3 masters, MAX_HOLD=4) against a transaction-level ownership model.
module tb_minx_bus_matrix;
  localparam int NM = 3;
  localparam int NS = 13;
  localparam int AW = 24;
  localparam int DW = 8;
  localparam int MH = 4;

  logic            clk = 1'b0;
  logic            reset, clk_ce, cpu_sync;
  logic [NM-1:0]   m_req, m_ack, m_write, m_read;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM*2-1:0] m_status;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata, ext_rdata, rdata;
  logic            bus_write, bus_read, bus_write_dly, in_window, hold_timeout;
  logic [1:0]      bus_status;
  logic [NS*DW-1:0] s_rdata;

  minx_bus_matrix #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
    .REG_BASE(32'h2000), .REG_SIZE(32'h100), .MEM_READ_CODE(2'b01), .MAX_HOLD(MH)
  ) dut (
    .clk(clk), .reset(reset), .clk_ce(clk_ce), .cpu_sync(cpu_sync),
    .m_req(m_req), .m_ack(m_ack), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_write(m_write), .m_read(m_read), .m_status(m_status),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_write(bus_write),
    .bus_read(bus_read), .bus_status(bus_status), .bus_write_dly(bus_write_dly),
    .s_rdata(s_rdata), .ext_rdata(ext_rdata), .rdata(rdata),
    .in_window(in_window), .hold_timeout(hold_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NM-1:0] ack;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr;
    logic          rd;
    logic [1:0]    st;
    logic          dly;
    logic          inw;
    logic [DW-1:0] rdata;
    logic          tmo;
  } exp_t;

  exp_t exp_q[$];
  int compared = 0;
  int mismatched = 0;

  // Ownership model: owner 0 = CPU, k>0 = master k, -1 = turnaround tick.
  int            owner = 0;
  int            held = 0;
  int            last = NM - 1;
  logic [NM-1:0] penalty = '0;
  logic          dly_m = 1'b0;
  logic          pulse_m = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      if (mismatched <= 40)
        $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    owner = 0; held = 0; last = NM - 1; penalty = '0; dly_m = 1'b0; pulse_m = 1'b0;
  endtask

  function automatic int pick(logic [NM-1:0] el);
`ifdef BUS_MATRIX_ROUND_ROBIN_EN
    for (int i = 1; i < NM; i++) begin
      int k;
      k = ((last - 1 + i) % (NM - 1)) + 1;
      if (el[k]) return k;
    end
`else
    for (int k = 1; k < NM; k++) if (el[k]) return k;
`endif
    return 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int sel;
    logic [DW-1:0] orr;
    sel = (owner > 0) ? owner : 0;
    e.ack = '0;
    if (owner == 0) e.ack[0] = 1'b1;
    else if (owner > 0) e.ack[owner] = 1'b1;
    e.addr  = m_addr[sel*AW +: AW];
    e.wdata = m_wdata[sel*DW +: DW];
    e.st    = m_status[sel*2 +: 2];
    e.wr    = reset && (owner >= 0) && m_write[sel];
    e.rd    = reset && (owner >= 0) && m_read[sel];
    e.dly   = dly_m;
    e.tmo   = pulse_m;
    e.inw   = (e.addr >= 24'h2000) && (e.addr < 24'h2100);
    orr = '0;
    for (int i = 0; i < NS; i++) orr = orr | s_rdata[i*DW +: DW];
    e.rdata = (e.inw && e.st == 2'b01) ? orr : ext_rdata;
    return e;
  endfunction

  task automatic model_edge(logic wr_now);
    logic [NM-1:0] el, npen;
    if (!reset) return;
    pulse_m = 1'b0;
    if (!clk_ce) return;
    el = m_req & ~penalty;
    el[0] = 1'b0;
    npen = penalty & m_req;
    dly_m = wr_now;
    if (owner == 0) begin
      if (el != '0 && cpu_sync) begin
        owner = pick(el); last = owner; held = 0;
      end
    end else if (owner > 0) begin
      held++;
      if (!m_req[owner]) owner = -1;
      else if (held == MH) begin
        npen[owner] = 1'b1; pulse_m = 1'b1; owner = -1;
      end
    end else begin
      owner = 0;
    end
    penalty = npen;
  endtask

  // Inputs are set at a negedge before calling; expectation is queued, then the model steps at posedge.
  task automatic tick();
    exp_t e;
    if (!reset) model_reset();
    #1;
    e = model_out();
    exp_q.push_back(e);
    @(posedge clk);
    model_edge(e.wr);
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 1'b1; clk_ce = 1'b1; cpu_sync = 1'b0; m_req = '0;
    m_addr = '0; m_wdata = '0; m_write = '0; m_read = '0; m_status = '0;
    s_rdata = '0; ext_rdata = '0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(5))
      0: return 24'h1FFF;
      1: return 24'h2000;
      2: return 24'h20FF;
      3: return 24'h2100;
      4: return 24'h2000 + 24'($urandom_range(255));
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic rand_inputs();
    reset    = ($urandom_range(199) != 0);
    clk_ce   = ($urandom_range(3) != 0);
    cpu_sync = ($urandom_range(2) == 0);
    m_req[0] = 1'($urandom_range(1));
    for (int k = 1; k < NM; k++) if ($urandom_range(7) == 0) m_req[k] = ~m_req[k];
    for (int k = 0; k < NM; k++) begin
      m_addr[k*AW +: AW]  = rand_addr();
      m_wdata[k*DW +: DW] = 8'($urandom);
      m_status[k*2 +: 2]  = 2'($urandom);
    end
    m_write   = NM'($urandom);
    m_read    = NM'($urandom);
    s_rdata   = '0;
    s_rdata[$urandom_range(NS-1)*DW +: DW] = 8'($urandom);
    s_rdata[$urandom_range(NS-1)*DW +: DW] = 8'($urandom);
    ext_rdata = 8'($urandom);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("m_ack",         32'(m_ack),         32'(e.ack));
        chk("bus_addr",      32'(bus_addr),      32'(e.addr));
        chk("bus_wdata",     32'(bus_wdata),     32'(e.wdata));
        chk("bus_write",     32'(bus_write),     32'(e.wr));
        chk("bus_read",      32'(bus_read),      32'(e.rd));
        chk("bus_status",    32'(bus_status),    32'(e.st));
        chk("bus_write_dly", 32'(bus_write_dly), 32'(e.dly));
        chk("in_window",     32'(in_window),     32'(e.inw));
        chk("rdata",         32'(rdata),         32'(e.rdata));
        chk("hold_timeout",  32'(hold_timeout),  32'(e.tmo));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    idle();
    reset = 1'b0;
    @(negedge clk);
    tick(); tick();
    reset = 1'b1;
    tick(); tick();

    // Request held off until the CPU sync boundary, then released.
    m_req = 3'b010; m_addr[AW +: AW] = 24'h123456; m_read[1] = 1'b1;
    repeat (3) tick();
    cpu_sync = 1'b1; tick();
    cpu_sync = 1'b0; tick(); tick();
    m_req = '0; repeat (3) tick();

    // Register-window read routing and boundaries.
    idle();
    m_addr[0 +: AW] = 24'h20FF; m_status[1:0] = 2'b01; s_rdata[3*DW +: DW] = 8'h18; ext_rdata = 8'h5A;
    tick();
    m_addr[0 +: AW] = 24'h2100; tick();
    m_addr[0 +: AW] = 24'h2050; m_status[1:0] = 2'b10; tick();
    m_addr[0 +: AW] = 24'h1FFF; m_status[1:0] = 2'b01; tick();
    m_addr[0 +: AW] = 24'h2000; tick();

    // Two requesters held high.
    idle(); m_req = 3'b110; cpu_sync = 1'b1;
    repeat (24) tick();

    // Stuck requester: timeout, turnaround, no regrant until seen low.
    idle(); tick();
    m_req = 3'b010; cpu_sync = 1'b1; m_write[1] = 1'b1;
    repeat (10) tick();
    m_req = '0; tick();
    m_req = 3'b010; repeat (3) tick();

    // Reset asserted mid-grant, between clock edges.
    idle(); m_req = 3'b010; cpu_sync = 1'b1; m_write[1] = 1'b1;
    repeat (3) tick();
    reset = 1'b0; tick();
    reset = 1'b1; repeat (4) tick();

    idle();
    repeat (3000) begin
      rand_inputs();
      tick();
    end

    repeat (3) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
